// File: rtl/wramp_core.sv
// -----------------------------------------------------------------------------
// wramp_core
//
// Multi-cycle 32-bit WRAMP-subset processor. Each instruction takes two
// clocks: FETCH reads the instruction word into IR and bumps the PC, then
// EXEC performs the register write, store or PC redirect.
//
// Architectural state:
//   - 16 x 32-bit register file ($0 always reads as zero, writes discarded)
//   - 20-bit word-addressed PC, 32-bit instruction register
//
// Memory timing: one shared port. Read data is expected combinationally for
// the address driven in the same cycle. A write commits at the rising edge
// that ends a cycle in which mem_write_enable is high. There is no
// handshake; the memory must always respond within the cycle.
//
// Ports:
//   clk               system clock, all state updates on the rising edge
//   rst_async         asynchronous active-high reset
//   mem_address       word address: PC in FETCH, effective address for lw/sw
//   mem_read_value    memory data at mem_address (combinational)
//   mem_write_enable  store strobe, high only in the EXEC cycle of sw
//   mem_write_value   store data (register Rd), zero otherwise
// -----------------------------------------------------------------------------
module wramp_core #(
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic        clk,
  input  logic        rst_async,
  output logic [19:0] mem_address,
  input  logic [31:0] mem_read_value,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_value
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ITYPE = 4'h1;
  localparam logic [3:0] OP_J     = 4'h4;
  localparam logic [3:0] OP_JR    = 4'h5;
  localparam logic [3:0] OP_JAL   = 4'h6;
  localparam logic [3:0] OP_JALR  = 4'h7;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'h9;
  localparam logic [3:0] OP_BEQZ  = 4'ha;
  localparam logic [3:0] OP_BNEZ  = 4'hb;

  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_ADDU = 4'h1;
  localparam logic [3:0] FN_SUB  = 4'h2;
  localparam logic [3:0] FN_SUBU = 4'h3;
  localparam logic [3:0] FN_SLL  = 4'ha;
  localparam logic [3:0] FN_AND  = 4'hb;
  localparam logic [3:0] FN_SRL  = 4'hc;
  localparam logic [3:0] FN_OR   = 4'hd;
  localparam logic [3:0] FN_SRA  = 4'he;
  localparam logic [3:0] FN_XOR  = 4'hf;

  localparam logic [3:0] LINK_REG = 4'hf;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [19:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  func;
  logic [3:0]  rt;
  logic [15:0] imm16;
  logic [19:0] off20;

  assign op    = ir_q[31:28];
  assign rd    = ir_q[27:24];
  assign rs    = ir_q[23:20];
  assign func  = ir_q[19:16];
  assign rt    = ir_q[3:0];
  assign imm16 = ir_q[15:0];
  assign off20 = ir_q[19:0];

  // Register reads; $0 is forced to zero here rather than relying on the
  // stored value so the read path never depends on the write guard.
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] rd_val;

  assign rs_val = (rs == 4'h0) ? 32'h0 : regs_q[rs];
  assign rt_val = (rt == 4'h0) ? 32'h0 : regs_q[rt];
  assign rd_val = (rd == 4'h0) ? 32'h0 : regs_q[rd];

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [4:0]  shamt;

  // Only the signed add/sub immediates are sign-extended; the unsigned
  // arithmetic, logical and shift forms take a zero-extended immediate.
  always_comb begin
    alu_b = rt_val;
    if (op == OP_ITYPE) begin
      if (func == FN_ADD || func == FN_SUB) begin
        alu_b = {{16{imm16[15]}}, imm16};
      end else begin
        alu_b = {16'h0000, imm16};
      end
    end
  end

  assign shamt = alu_b[4:0];

  // Unimplemented function codes (multiply/divide/remainder) yield zero.
  always_comb begin
    alu_result = 32'h0;
    case (func)
      FN_ADD,
      FN_ADDU: alu_result = rs_val + alu_b;
      FN_SUB,
      FN_SUBU: alu_result = rs_val - alu_b;
      FN_SLL:  alu_result = rs_val << shamt;
      FN_AND:  alu_result = rs_val & alu_b;
      FN_SRL:  alu_result = rs_val >> shamt;
      FN_OR:   alu_result = rs_val | alu_b;
      FN_SRA:  alu_result = $signed(rs_val) >>> shamt;
      FN_XOR:  alu_result = rs_val ^ alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  // Effective address: 20-bit add is equivalent to sign-extending the
  // offset to 32 bits and truncating the sum.
  logic [19:0] eff_addr;
  assign eff_addr = rs_val[19:0] + off20;

  // ---------------------------------------------------------------------------
  // Next state, register writeback and memory port
  // ---------------------------------------------------------------------------
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    regs_d           = regs_q;
    mem_address      = pc_q;
    mem_write_enable = 1'b0;
    mem_write_value  = 32'h0;
    rf_we            = 1'b0;
    rf_waddr         = rd;
    rf_wdata         = 32'h0;

    case (state_q)
      S_FETCH: begin
        ir_d    = mem_read_value;
        pc_d    = pc_q + 20'd1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_RTYPE,
          OP_ITYPE: begin
            rf_we    = 1'b1;
            rf_wdata = alu_result;
          end
          OP_LW: begin
            mem_address = eff_addr;
            rf_we       = 1'b1;
            rf_wdata    = mem_read_value;
          end
          OP_SW: begin
            mem_address      = eff_addr;
            mem_write_enable = 1'b1;
            mem_write_value  = rd_val;
          end
          OP_J: begin
            pc_d = off20;
          end
          OP_JR: begin
            pc_d = rs_val[19:0];
          end
          // pc_q already points past this instruction, so it is the
          // return address as-is.
          OP_JAL: begin
            rf_we    = 1'b1;
            rf_waddr = LINK_REG;
            rf_wdata = {12'h000, pc_q};
            pc_d     = off20;
          end
          OP_JALR: begin
            rf_we    = 1'b1;
            rf_waddr = LINK_REG;
            rf_wdata = {12'h000, pc_q};
            pc_d     = rs_val[19:0];
          end
          OP_BEQZ: begin
            if (rs_val == 32'h0) begin
              pc_d = pc_q + off20;
            end
          end
          OP_BNEZ: begin
            if (rs_val != 32'h0) begin
              pc_d = pc_q + off20;
            end
          end
          default: begin
          end
        endcase
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rf_we && (rf_waddr != 4'h0)) begin
      regs_d[rf_waddr] = rf_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset is asynchronous, so an instruction interrupted in
  // EXEC never reaches its writeback edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wramp_core.sv
// -----------------------------------------------------------------------------
// tb_wramp_core
//
// Bench for wramp_core. The bench owns a word memory that the core reads
// combinationally. Each program's expected stores ({address, data}) are
// queued before the core is released from reset; a negedge monitor pops and
// compares every store the core issues. A store of 0x0000dead to 0xfffff
// marks the end of a program.
// -----------------------------------------------------------------------------
module tb_wramp_core;

  logic        clk;
  logic        rst_async;
  logic [19:0] mem_address;
  logic [31:0] mem_read_value;
  logic        mem_write_enable;
  logic [31:0] mem_write_value;

  wramp_core #(
    .RESET_PC(20'h00000)
  ) dut (
    .clk              (clk),
    .rst_async        (rst_async),
    .mem_address      (mem_address),
    .mem_read_value   (mem_read_value),
    .mem_write_enable (mem_write_enable),
    .mem_write_value  (mem_write_value)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory (loaded only by the stimulus process; core stores go to the
  // scoreboard instead)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:1048575];
  assign mem_read_value = mem[mem_address];

  localparam logic [31:0] FILLER = 32'h91000033;  // sw $1,0x33: any stray execution shows up as a store

  // ---------------------------------------------------------------------------
  // Scoreboard state and checker
  // ---------------------------------------------------------------------------
  logic [51:0] exp_q[$];
  logic [31:0] prog_q[$];
  int          n_checks;
  int          n_pass;
  int          cyc;
  int          done_cycle;
  logic        done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycles since reset release; cyc edges have elapsed when sampled at a negedge.
  always @(posedge clk or posedge rst_async) begin
    if (rst_async) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  // Store monitor
  always @(negedge clk) begin
    if (rst_async) begin
      done = 1'b0;
    end else if (!done && mem_write_enable) begin
      if (mem_address == 20'hfffff && mem_write_value == 32'h0000dead) begin
        done       = 1'b1;
        done_cycle = cyc + 1;
      end else if (exp_q.size() == 0) begin
        check_eq("stray_store", {11'h0, 1'b1, mem_address, mem_write_value}, 64'h0);
      end else begin
        check_eq("store", {12'h0, mem_address, mem_write_value}, {12'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic enter_reset();
    @(negedge clk);
    rst_async = 1'b1;
    #1;
    check_eq("rst_addr", {44'h0, mem_address}, 64'h0);
    check_eq("rst_we", {63'h0, mem_write_enable}, 64'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    for (int a = 0; a < 256; a++) mem[a] = FILLER;
  endtask

  task automatic load_prog(input logic [19:0] base);
    for (int i = 0; i < prog_q.size(); i++) mem[base + 20'(i)] = prog_q[i];
  endtask

  task automatic expect_store(input logic [19:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_async = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done) break;
    end
    check_eq("done_seen", {63'h0, done}, 64'h1);
    check_eq("exp_q_left", 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic found;
    n_checks   = 0;
    n_pass     = 0;
    done_cycle = 0;
    rst_async  = 1'b1;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check_eq("reset_addr", {44'h0, mem_address}, 64'h0);
    check_eq("reset_we", {63'h0, mem_write_enable}, 64'h0);
    check_eq("reset_wval", {32'h0, mem_write_value}, 64'h0);

    // ---- Sum loop over mem[10..17] ----
    enter_reset();
    prog_q = '{32'h1100000a, 32'h020b0000, 32'h83100000, 32'h02200003, 32'h11100001,
               32'h14120012, 32'hb04ffffb, 32'h920000ff, 32'h1f0ddead, 32'h9f0fffff,
               32'h10000000, 32'h02000000, 32'h00300000, 32'h00040000,
               32'h00005000, 32'h00000600, 32'h00000070, 32'h00000008};
    load_prog(20'h0);
    expect_store(20'h000ff, 32'h12345678);
    release_reset();
    #1;
    check_eq("fetch0_addr", {44'h0, mem_address}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("fetch1_addr", {44'h0, mem_address}, 64'h1);
    run_until_done(300);
    check_eq("sum_end_cycle", 64'(done_cycle), 64'd90);

    // ---- ALU corner cases ----
    enter_reset();
    prog_q = '{32'h1100ffff, 32'h1201ffff, 32'h13000001, 32'h133a001f, 32'h143c0004,
               32'h153e0004, 32'h06120002, 32'h071f0003, 32'h081d0000, 32'h08140002,
               32'h19008000, 32'h1a018000, 32'h0b1b0003, 32'h1c038000, 32'h1d028000,
               32'h91000041, 32'h92000042, 32'h93000043, 32'h94000044, 32'h95000045,
               32'h96000046, 32'h97000047, 32'h98000048, 32'h99000049, 32'h9a00004a,
               32'h9b00004b, 32'h9c00004c, 32'h9d00004d,
               32'h1f0ddead, 32'h9f0fffff, 32'h4000001e};
    load_prog(20'h0);
    expect_store(20'h41, 32'hffffffff);  // addi -1
    expect_store(20'h42, 32'h0000ffff);  // addui 0xffff
    expect_store(20'h43, 32'h80000000);  // slli by 31
    expect_store(20'h44, 32'h08000000);  // srli by 4
    expect_store(20'h45, 32'hf8000000);  // srai by 4
    expect_store(20'h46, 32'hffff0000);  // sub
    expect_store(20'h47, 32'h7fffffff);  // xor
    expect_store(20'h48, 32'h00000000);  // unimplemented func clears rd
    expect_store(20'h49, 32'hffff8000);  // addi sign-extends
    expect_store(20'h4a, 32'h00008000);  // addui zero-extends
    expect_store(20'h4b, 32'h80000000);  // and
    expect_store(20'h4c, 32'hffff8000);  // subui zero-extends
    expect_store(20'h4d, 32'h00008000);  // subi sign-extends
    release_reset();
    run_until_done(300);

    // ---- $0, branches and jumps ----
    enter_reset();
    prog_q = '{32'h10000005, 32'h90000020, 32'ha0000002, FILLER, FILLER,
               32'h11000007, 32'ha0100005, 32'h91000021, 32'h40000010};
    load_prog(20'h00);
    prog_q = '{32'h60000014, 32'h9f000022, 32'h40000018, FILLER, 32'h50f00000};
    load_prog(20'h10);
    prog_q = '{32'h12010020, 32'h70200000};
    load_prog(20'h18);
    prog_q = '{32'h9f000023, 32'hb0100002, FILLER, FILLER, 32'hb0000005,
               32'hc0000000, 32'h1f0ddead, 32'h9f0fffff, 32'h40000028};
    load_prog(20'h20);
    expect_store(20'h20, 32'h00000000);  // $0 stays zero
    expect_store(20'h21, 32'h00000007);  // beqz not taken falls through
    expect_store(20'h22, 32'h00000011);  // jal link
    expect_store(20'h23, 32'h0000001a);  // jalr link
    release_reset();
    run_until_done(300);

    // ---- Reset asserted during the EXEC cycle of a store ----
    enter_reset();
    prog_q = '{32'h11000055, 32'h91000030, 32'h1f0ddead, 32'h9f0fffff, 32'h40000004};
    load_prog(20'h0);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mem_write_enable) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("sw_exec_seen", {63'h0, found}, 64'h1);
    check_eq("sw_exec_addr", {44'h0, mem_address}, 64'h30);
    rst_async = 1'b1;
    #1;
    check_eq("abort_we", {63'h0, mem_write_enable}, 64'h0);
    check_eq("abort_addr", {44'h0, mem_address}, 64'h0);
    check_eq("abort_wval", {32'h0, mem_write_value}, 64'h0);
    repeat (2) @(negedge clk);
    expect_store(20'h30, 32'h00000055);
    release_reset();
    run_until_done(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
